multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multicycle MIPS datapath. It decodes the instruction opcode and steps each instruction through fetch, decode, execute, memory and writeback states. In each state it drives the datapath mux selects, the register, PC and memory enables, and the 2-bit `AluOp` consumed by `alucontrol`. Memory accesses are stretched by a `mem_ready` handshake so the block works with single-cycle or wait-stated memory.

## Interface
- No parameters; opcode set and state encoding are fixed.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `Op` in 6: instruction opcode (IR[31:26]); sampled in DECODE and in the state following DECODE.
- `mem_ready` in 1: memory completes the current access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `RegWrite`, `RegDst`, `AluSrcA` out 1 each: standard multicycle datapath controls.
- `AluSrcB` out 2: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `PCSource` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `AluOp` out 2: 00 = add, 01 = subtract, 10 = use function field.
- `state` out 4: current state, for debug and bench.
- `illegal_op` out 1: one-cycle pulse when DECODE sees an unsupported opcode.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 are unreachable and go to FETCH on the next edge.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- Transitions:
  - FETCH → DECODE when `mem_ready`=1; otherwise stay in FETCH.
  - DECODE → MEMADR (lw/sw), EXEC (R-type), BRANCH (beq), JUMP (j), ADDIEX (addi). Any other opcode → FETCH, with `illegal_op`=1 in that DECODE cycle.
  - MEMADR → MEMRD (lw) or MEMWR (sw).
  - MEMRD → MEMWB when `mem_ready`; otherwise hold.
  - MEMWR → FETCH when `mem_ready`; otherwise hold.
  - EXEC → ALUWB; ADDIEX → ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP → FETCH.
- Output decode is Moore from `state`, except `IRWrite` and `PCWrite` in FETCH, which equal `mem_ready`. Any signal not listed for a state is 0.
  - FETCH: `MemRead`=1, `IorD`=0, `AluSrcA`=0, `AluSrcB`=01, `AluOp`=00, `PCSource`=00, `IRWrite`=`PCWrite`=`mem_ready`.
  - DECODE: `AluSrcA`=0, `AluSrcB`=11, `AluOp`=00 (branch target into ALUOut).
  - MEMADR, ADDIEX: `AluSrcA`=1, `AluSrcB`=10, `AluOp`=00.
  - MEMRD: `MemRead`=1, `IorD`=1.
  - MEMWR: `MemWrite`=1, `IorD`=1.
  - MEMWB: `RegWrite`=1, `MemtoReg`=1, `RegDst`=0.
  - EXEC: `AluSrcA`=1, `AluSrcB`=00, `AluOp`=10.
  - ALUWB: `RegWrite`=1, `MemtoReg`=0, `RegDst`=1.
  - ADDIWB: `RegWrite`=1, `MemtoReg`=0, `RegDst`=0.
  - BRANCH: `AluSrcA`=1, `AluSrcB`=00, `AluOp`=01, `PCWriteCond`=1, `PCSource`=01.
  - JUMP: `PCWrite`=1, `PCSource`=10.
- All write enables (`PCWrite`, `PCWriteCond`, `IRWrite`, `RegWrite`, `MemWrite`) are ANDed with `rst_n`, so no write can occur while reset is asserted.

## Timing
- Reset: `rst_n`=0 forces `state`=FETCH immediately, without waiting for a clock edge.
  - While in reset, every write enable is 0, `illegal_op`=0, `MemRead`=1, `AluSrcB`=01, and all other outputs are 0.
  - First fetch: on the first rising edge after `rst_n` rises. If `mem_ready` was high during reset, that edge already advances to DECODE.
- Cycle counts with `mem_ready` tied high:
  - lw: 5 cycles.
  - sw, R-type, addi: 4 cycles.
  - beq, j: 3 cycles.
- Each cycle `mem_ready` is low in FETCH, MEMRD or MEMWR adds one cycle. While waiting, the state's outputs are held stable and `IRWrite`/`PCWrite` stay 0.
- `Op` changing in any state other than DECODE or MEMADR has no effect.
- Reset asserted mid-instruction aborts the instruction. No partial write completes after `rst_n` falls.

## Test plan
- Reset with `mem_ready`=1: `state`=0, `MemRead`=1, `PCWrite`=`IRWrite`=0 during reset. The edge after release gives `state`=1, with `PCWrite`=`IRWrite`=1 for exactly one cycle beforehand.
- `Op`=100011, `mem_ready`=1: state sequence 0,1,2,3,4,0. `RegWrite`=`MemtoReg`=1 only in state 4.
- `Op`=101011 with `mem_ready` low for 3 cycles in MEMWR: `state` holds at 5 for 4 cycles with `MemWrite`=1 and `IorD`=1 throughout, then returns to 0.
- `Op`=000000: `AluOp`=10 in state 6; state 7 has `RegDst`=1 and `RegWrite`=1. `Op`=000100: state 8 has `AluOp`=01, `PCWriteCond`=1 and `PCSource`=01.
- `Op`=111111: `illegal_op`=1 for one cycle in DECODE, next state 0, and no write enable asserts.
- `rst_n` dropped while in MEMWB: `state`=0 and `RegWrite`=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Steps each instruction through fetch/decode/execute/memory/writeback and drives
// the datapath mux selects, write enables and the 2-bit ALU op for alucontrol.
// Memory states stretch on mem_ready so wait-stated memories are supported.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       AluSrcA,
    output logic [1:0] AluSrcB,
    output logic [1:0] PCSource,
    output logic [1:0] AluOp,
    output logic [3:0] state,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StAddiEx = 4'd9,
        StAddiWb = 4'd10,
        StJump   = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;

    // ALU source B selects
    localparam logic [1:0] SrcBReg    = 2'b00;
    localparam logic [1:0] SrcBFour   = 2'b01;
    localparam logic [1:0] SrcBImm    = 2'b10;
    localparam logic [1:0] SrcBImmSh2 = 2'b11;

    // PC source selects
    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    // ALU op codes for alucontrol
    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    state_e r_state;
    state_e w_state_next;
    logic   w_illegal_op;

    // Raw (pre-reset-gating) write enables
    logic w_pc_write;
    logic w_pc_write_cond;
    logic w_ir_write;
    logic w_reg_write;
    logic w_mem_write;

    // State register; reset forces FETCH without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode, including opcode dispatch and illegal-opcode detection.
    always_comb begin
        w_state_next = r_state;
        w_illegal_op = 1'b0;
        unique case (r_state)
            StFetch: begin
                if (mem_ready) begin
                    w_state_next = StDecode;
                end
            end
            StDecode: begin
                case (Op)
                    OpLw, OpSw: w_state_next = StMemAdr;
                    OpRtype:    w_state_next = StExec;
                    OpBeq:      w_state_next = StBranch;
                    OpJ:        w_state_next = StJump;
                    OpAddi:     w_state_next = StAddiEx;
                    default: begin
                        w_state_next = StFetch;
                        w_illegal_op = 1'b1;
                    end
                endcase
            end
            StMemAdr: begin
                // Op is re-sampled here to pick load or store.
                if (Op == OpLw) begin
                    w_state_next = StMemRd;
                end else if (Op == OpSw) begin
                    w_state_next = StMemWr;
                end else begin
                    w_state_next = StFetch;
                end
            end
            StMemRd: begin
                if (mem_ready) begin
                    w_state_next = StMemWb;
                end
            end
            StMemWr: begin
                if (mem_ready) begin
                    w_state_next = StFetch;
                end
            end
            StExec:   w_state_next = StAluWb;
            StAddiEx: w_state_next = StAddiWb;
            StMemWb, StAluWb, StAddiWb, StBranch, StJump: begin
                w_state_next = StFetch;
            end
            // Unreachable encodings recover to FETCH.
            default:  w_state_next = StFetch;
        endcase
    end

    // Moore output decode; only IRWrite/PCWrite in FETCH follow mem_ready.
    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_ir_write      = 1'b0;
        w_reg_write     = 1'b0;
        w_mem_write     = 1'b0;
        IorD            = 1'b0;
        MemRead         = 1'b0;
        MemtoReg        = 1'b0;
        RegDst          = 1'b0;
        AluSrcA         = 1'b0;
        AluSrcB         = SrcBReg;
        PCSource        = PcSrcAlu;
        AluOp           = AluOpAdd;
        unique case (r_state)
            StFetch: begin
                MemRead    = 1'b1;
                AluSrcB    = SrcBFour;
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
            end
            StDecode: begin
                // Branch target computed speculatively into ALUOut.
                AluSrcB = SrcBImmSh2;
            end
            StMemAdr, StAddiEx: begin
                AluSrcA = 1'b1;
                AluSrcB = SrcBImm;
            end
            StMemRd: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            StMemWr: begin
                w_mem_write = 1'b1;
                IorD        = 1'b1;
            end
            StMemWb: begin
                w_reg_write = 1'b1;
                MemtoReg    = 1'b1;
            end
            StExec: begin
                AluSrcA = 1'b1;
                AluOp   = AluOpFunct;
            end
            StAluWb: begin
                w_reg_write = 1'b1;
                RegDst      = 1'b1;
            end
            StAddiWb: begin
                w_reg_write = 1'b1;
            end
            StBranch: begin
                AluSrcA         = 1'b1;
                AluOp           = AluOpSub;
                w_pc_write_cond = 1'b1;
                PCSource        = PcSrcAluOut;
            end
            StJump: begin
                w_pc_write = 1'b1;
                PCSource   = PcSrcJump;
            end
            default: begin
                AluSrcB = SrcBReg;
            end
        endcase
    end

    // Gate every write enable with reset so nothing commits while rst_n is low.
    assign PCWrite     = w_pc_write & rst_n;
    assign PCWriteCond = w_pc_write_cond & rst_n;
    assign IRWrite     = w_ir_write & rst_n;
    assign RegWrite    = w_reg_write & rst_n;
    assign MemWrite    = w_mem_write & rst_n;
    assign illegal_op  = w_illegal_op & rst_n;
    assign state       = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-instruction state sequences and control words.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] Op = 6'd0;
    logic       mem_ready = 1'b1;

    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, RegWrite, RegDst, AluSrcA, illegal_op;
    logic [1:0] AluSrcB, PCSource, AluOp;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    multicycle_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Op         (Op),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemtoReg   (MemtoReg),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .AluSrcA    (AluSrcA),
        .AluSrcB    (AluSrcB),
        .PCSource   (PCSource),
        .AluOp      (AluOp),
        .state      (state),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,RegWrite,RegDst,AluSrcA}
    //   _AluSrcB_PCSource_AluOp_illegal_op
    wire [16:0] ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                        RegWrite, RegDst, AluSrcA, AluSrcB, PCSource, AluOp, illegal_op};
    wire [4:0]  wen  = {PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite};

    localparam logic [16:0] C_FETCH_IDLE = 17'b0001000000_01_00_00_0;
    localparam logic [16:0] C_FETCH_RDY  = 17'b1001001000_01_00_00_0;
    localparam logic [16:0] C_DECODE     = 17'b0000000000_11_00_00_0;
    localparam logic [16:0] C_ILLEGAL    = 17'b0000000000_11_00_00_1;
    localparam logic [16:0] C_MEMADR     = 17'b0000000001_10_00_00_0;
    localparam logic [16:0] C_MEMRD      = 17'b0011000000_00_00_00_0;
    localparam logic [16:0] C_MEMWR      = 17'b0010100000_00_00_00_0;
    localparam logic [16:0] C_MEMWB      = 17'b0000010100_00_00_00_0;
    localparam logic [16:0] C_EXEC       = 17'b0000000001_00_00_10_0;
    localparam logic [16:0] C_ALUWB      = 17'b0000000110_00_00_00_0;
    localparam logic [16:0] C_ADDIWB     = 17'b0000000100_00_00_00_0;
    localparam logic [16:0] C_BRANCH     = 17'b0100000001_00_01_01_0;
    localparam logic [16:0] C_JUMP       = 17'b1000000000_00_10_00_0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset across one edge; returns just after the edge with the DUT in FETCH.
    task automatic do_reset(input logic mr);
        rst_n     = 1'b0;
        mem_ready = mr;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        Op        = 6'b000000;
        #3;
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL reset_state_async: got %0d want 0", state);
        end
        checks++;
        if (ctrl !== C_FETCH_IDLE) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want %b", ctrl, C_FETCH_IDLE);
        end
        tick();
        checks++;
        if (state !== 4'd0 || wen !== 5'd0) begin
            errors++;
            $display("FAIL reset_held_over_edge: state %0d wen %b want 0 00000", state, wen);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (ctrl !== C_FETCH_RDY) begin
            errors++;
            $display("FAIL first_fetch_ctrl: got %b want %b", ctrl, C_FETCH_RDY);
        end
        tick();
        checks++;
        if (state !== 4'd1) begin
            errors++;
            $display("FAIL first_fetch_advance: got %0d want 1", state);
        end
        checks++;
        if (ctrl !== C_DECODE) begin
            errors++;
            $display("FAIL decode_ctrl: got %b want %b", ctrl, C_DECODE);
        end
    endtask

    task automatic test_lw();
        logic [3:0]  exp_st [6];
        logic [16:0] exp_c  [6];
        exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        exp_c  = '{C_FETCH_RDY, C_DECODE, C_MEMADR, C_MEMRD, C_MEMWB, C_FETCH_RDY};
        Op = 6'b100011;
        do_reset(1'b1);
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (state !== exp_st[i]) begin
                errors++;
                $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
            end
            checks++;
            if (ctrl !== exp_c[i]) begin
                errors++;
                $display("FAIL lw_ctrl[%0d]: got %b want %b", i, ctrl, exp_c[i]);
            end
            tick();
        end
    endtask

    task automatic test_fetch_wait_beq();
        Op = 6'b000100;
        do_reset(1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (state !== 4'd0 || ctrl !== C_FETCH_IDLE) begin
                errors++;
                $display("FAIL fetch_wait[%0d]: state %0d ctrl %b want 0 %b", i, state, ctrl,
                         C_FETCH_IDLE);
            end
            tick();
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (ctrl !== C_FETCH_RDY) begin
            errors++;
            $display("FAIL fetch_ready_ctrl: got %b want %b", ctrl, C_FETCH_RDY);
        end
        tick();
        checks++;
        if (state !== 4'd1) begin
            errors++;
            $display("FAIL beq_decode: got %0d want 1", state);
        end
        tick();
        checks++;
        if (state !== 4'd8 || ctrl !== C_BRANCH) begin
            errors++;
            $display("FAIL beq_branch: state %0d ctrl %b want 8 %b", state, ctrl, C_BRANCH);
        end
        tick();
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL beq_return: got %0d want 0", state);
        end
    endtask

    task automatic test_sw_wait();
        Op = 6'b101011;
        do_reset(1'b1);
        tick();
        tick();
        checks++;
        if (state !== 4'd2 || ctrl !== C_MEMADR) begin
            errors++;
            $display("FAIL sw_memadr: state %0d ctrl %b want 2 %b", state, ctrl, C_MEMADR);
        end
        tick();
        mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) mem_ready = 1'b1;
            #1;
            checks++;
            if (state !== 4'd5 || ctrl !== C_MEMWR) begin
                errors++;
                $display("FAIL sw_memwr[%0d]: state %0d ctrl %b want 5 %b", k, state, ctrl,
                         C_MEMWR);
            end
            tick();
        end
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL sw_return: got %0d want 0", state);
        end
    endtask

    task automatic test_rtype();
        logic [3:0]  exp_st [5];
        logic [16:0] exp_c  [5];
        exp_st = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        exp_c  = '{C_FETCH_RDY, C_DECODE, C_EXEC, C_ALUWB, C_FETCH_RDY};
        Op = 6'b000000;
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) begin
            // Opcode changing during EXEC must not redirect the instruction.
            if (i == 2) Op = 6'b100011;
            #1;
            checks++;
            if (state !== exp_st[i] || ctrl !== exp_c[i]) begin
                errors++;
                $display("FAIL rtype[%0d]: state %0d ctrl %b want %0d %b", i, state, ctrl,
                         exp_st[i], exp_c[i]);
            end
            tick();
        end
    endtask

    task automatic test_addi();
        logic [3:0]  exp_st [5];
        logic [16:0] exp_c  [5];
        exp_st = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
        exp_c  = '{C_FETCH_RDY, C_DECODE, C_MEMADR, C_ADDIWB, C_FETCH_RDY};
        Op = 6'b001000;
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (state !== exp_st[i] || ctrl !== exp_c[i]) begin
                errors++;
                $display("FAIL addi[%0d]: state %0d ctrl %b want %0d %b", i, state, ctrl,
                         exp_st[i], exp_c[i]);
            end
            tick();
        end
    endtask

    task automatic test_jump();
        Op = 6'b000010;
        do_reset(1'b1);
        tick();
        tick();
        checks++;
        if (state !== 4'd11 || ctrl !== C_JUMP) begin
            errors++;
            $display("FAIL jump: state %0d ctrl %b want 11 %b", state, ctrl, C_JUMP);
        end
        tick();
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL jump_return: got %0d want 0", state);
        end
    endtask

    task automatic test_illegal();
        Op = 6'b111111;
        do_reset(1'b1);
        tick();
        checks++;
        if (state !== 4'd1 || ctrl !== C_ILLEGAL || wen !== 5'd0) begin
            errors++;
            $display("FAIL illegal_decode: state %0d ctrl %b wen %b want 1 %b 00000", state,
                     ctrl, wen, C_ILLEGAL);
        end
        tick();
        checks++;
        if (state !== 4'd0 || illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL illegal_next: state %0d illegal %b want 0 0", state, illegal_op);
        end
    endtask

    task automatic test_reset_mid();
        Op = 6'b100011;
        do_reset(1'b1);
        repeat (4) tick();
        checks++;
        if (state !== 4'd4 || RegWrite !== 1'b1) begin
            errors++;
            $display("FAIL mid_memwb: state %0d RegWrite %b want 4 1", state, RegWrite);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || wen !== 5'd0 || ctrl !== C_FETCH_IDLE) begin
            errors++;
            $display("FAIL mid_reset_abort: state %0d wen %b ctrl %b want 0 00000 %b", state,
                     wen, ctrl, C_FETCH_IDLE);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_fetch_wait_beq();
        test_sw_wait();
        test_rtype();
        test_addi();
        test_jump();
        test_illegal();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
